// File: rtl/mul_arb_pkg.sv
// mul_arb_pkg: shared types for the two-requester iterative multiplier.
// Holds the default operand width, the FSM state enum, the requester-id
// type and the response record (id, product) sized for the default width.
package mul_arb_pkg;

  localparam int MUL_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef logic req_id_t;

  typedef struct packed {
    req_id_t              id;
    logic [2*MUL_W-1:0]   product;
  } rsp_t;

endpackage

// File: rtl/mul_shift_add.sv
// mul_shift_add: iterative unsigned shift-add multiplier, one multiplier bit
// per enabled cycle, LSB first, always exactly W steps after i_start.
// Ports: clk/rst_n/ena, i_start + i_a/i_b load operands, o_done flags that the
// pending step is the last one, o_product is the accumulator after that step.
module mul_shift_add
  import mul_arb_pkg::*;
#(
  parameter int W = MUL_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ena,
  input  logic           i_start,
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  output logic           o_done,
  output logic [2*W-1:0] o_product
);

  localparam int CW = $clog2(W) + 1;

  logic [CW-1:0]  r_cnt;
  logic [2*W-1:0] r_mcand;
  logic [W-1:0]   r_mplier;
  logic [2*W-1:0] r_acc;
  logic [2*W-1:0] w_acc_nxt;

  assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);

  // The product is taken from the combinational next-accumulator so the
  // owner can capture it on the same edge that performs the final step.
  assign o_done    = (r_cnt == CW'(1));
  assign o_product = w_acc_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
    end else if (ena) begin
      if (i_start) begin
        r_cnt    <= CW'(W);
        r_mcand  <= {{W{1'b0}}, i_a};
        r_mplier <= i_b;
        r_acc    <= '0;
      end else if (r_cnt != '0) begin
        r_acc    <= w_acc_nxt;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin arbiter feeding one iterative multiplier.
// Ports: two valid/ready operand requesters, one valid/ready response
// (id, product), global enable ena, busy when not idle.
module mul_arbiter
  import mul_arb_pkg::*;
#(
  parameter int W = MUL_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ena,
  input  logic           req0_valid,
  input  logic [W-1:0]   req0_a,
  input  logic [W-1:0]   req0_b,
  output logic           req0_ready,
  input  logic           req1_valid,
  input  logic [W-1:0]   req1_a,
  input  logic [W-1:0]   req1_b,
  output logic           req1_ready,
  output logic           rsp_valid,
  output req_id_t        rsp_id,
  output logic [2*W-1:0] rsp_product,
  input  logic           rsp_ready,
  output logic           busy
);

  state_t         r_state;
  req_id_t        r_last_grant;
  req_id_t        r_cur_id;
  logic           r_rsp_valid;
  req_id_t        r_rsp_id;
  logic [2*W-1:0] r_rsp_product;

  logic           w_gnt0;
  logic           w_gnt1;
  logic           w_rdy_en;
  logic           w_start;
  req_id_t        w_start_id;
  logic [W-1:0]   w_a;
  logic [W-1:0]   w_b;
  logic           w_done;
  logic [2*W-1:0] w_product;

  // With both pending, the requester not granted last wins.
  assign w_gnt0 = req0_valid && (!req1_valid || (r_last_grant == 1'b1));
  assign w_gnt1 = req1_valid && (!req0_valid || (r_last_grant == 1'b0));

  // rst_n is included so ready stays low for the whole reset window.
  assign w_rdy_en   = rst_n && ena && (r_state == ST_IDLE);
  assign req0_ready = w_rdy_en && w_gnt0;
  assign req1_ready = w_rdy_en && w_gnt1;

  assign w_start    = (req0_valid && req0_ready) || (req1_valid && req1_ready);
  assign w_start_id = req_id_t'(req1_ready);
  assign w_a        = req1_ready ? req1_a : req0_a;
  assign w_b        = req1_ready ? req1_b : req0_b;

  mul_shift_add #(.W(W)) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .i_start   (w_start),
    .i_a       (w_a),
    .i_b       (w_b),
    .o_done    (w_done),
    .o_product (w_product)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_last_grant  <= 1'b1;
      r_cur_id      <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_id      <= 1'b0;
      r_rsp_product <= '0;
    end else if (ena) begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_cur_id     <= w_start_id;
            r_last_grant <= w_start_id;
            r_state      <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (w_done) begin
            r_rsp_valid   <= 1'b1;
            r_rsp_id      <= r_cur_id;
            r_rsp_product <= w_product;
            r_state       <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rsp_valid   = r_rsp_valid;
  assign rsp_id      = r_rsp_id;
  assign rsp_product = r_rsp_product;
  assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mul_arbiter.sv
// tb_mul_arbiter: directed self-checking bench for mul_arbiter (W=4).
// Table of single-request vectors plus hand-written contention,
// backpressure, mid-operation reset and enable-gating sequences.
module tb_mul_arbiter;
  import mul_arb_pkg::*;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         ena;
  logic         req0_valid, req1_valid;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         req0_ready, req1_ready;
  logic         rsp_valid;
  req_id_t      rsp_id;
  logic [2*W-1:0] rsp_product;
  logic         rsp_ready;
  logic         busy;

  int n_checks = 0;
  int n_errors = 0;

  mul_arbiter #(.W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .req0_valid  (req0_valid),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .req1_ready  (req1_ready),
    .rsp_valid   (rsp_valid),
    .rsp_id      (rsp_id),
    .rsp_product (rsp_product),
    .rsp_ready   (rsp_ready),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Present a request at a negedge, let it be accepted on the next posedge,
  // then drop valid and scramble the operands at the following negedge.
  task automatic accept(input req_id_t id, input logic [W-1:0] a, input logic [W-1:0] b);
    if (id == 1'b0) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b;
    end
    #1;
    chk("ready_own", id ? req1_ready : req0_ready, 1);
    chk("ready_other", id ? req0_ready : req1_ready, 0);
    @(posedge clk);
    @(negedge clk);
    if (id == 1'b0) begin
      req0_valid = 1'b0; req0_a = W'($urandom); req0_b = W'($urandom);
    end else begin
      req1_valid = 1'b0; req1_a = W'($urandom); req1_b = W'($urandom);
    end
  endtask

  // Called at the negedge after the accepting edge (k=0); counts edges until
  // rsp_valid, optionally dropping ena for off_len cycles starting at k=off_at.
  task automatic wait_rsp(input int off_at, input int off_len, output int lat);
    int k;
    k = 0;
    while (!rsp_valid && k < 40) begin
      if (k == off_at) ena = 1'b0;
      if (k == off_at + off_len) ena = 1'b1;
      @(negedge clk);
      k++;
    end
    ena = 1'b1;
    lat = k;
  endtask

  typedef struct {
    req_id_t      id;
    logic [W-1:0] a;
    logic [W-1:0] b;
    rsp_t         exp;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int lat;
    int got_n, t, last_t;
    req_id_t exp_id;
    logic [2*W-1:0] exp_p;
    logic ok;

    vecs[0] = '{id: 1'b0, a: 4'd3,  b: 4'd5,  exp: '{id: 1'b0, product: 8'd15}};
    vecs[1] = '{id: 1'b0, a: 4'd0,  b: 4'd9,  exp: '{id: 1'b0, product: 8'd0}};
    vecs[2] = '{id: 1'b0, a: 4'd1,  b: 4'd15, exp: '{id: 1'b0, product: 8'd15}};
    vecs[3] = '{id: 1'b1, a: 4'd15, b: 4'd15, exp: '{id: 1'b1, product: 8'hE1}};
    vecs[4] = '{id: 1'b1, a: 4'd2,  b: 4'd7,  exp: '{id: 1'b1, product: 8'd14}};
    vecs[5] = '{id: 1'b0, a: 4'd9,  b: 4'd0,  exp: '{id: 1'b0, product: 8'd0}};

    rst_n = 1'b0; ena = 1'b1; rsp_ready = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    #23;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_product", rsp_product, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_req1_ready", req1_ready, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single-request vectors, each with full W-cycle latency.
    for (int i = 0; i < 6; i++) begin
      accept(vecs[i].id, vecs[i].a, vecs[i].b);
      chk("calc_busy", busy, 1);
      wait_rsp(-1, 0, lat);
      chk("vec_latency", lat, 4);
      chk("vec_id", rsp_id, vecs[i].exp.id);
      chk("vec_product", rsp_product, vecs[i].exp.product);
      chk("done_busy", busy, 1);
      @(negedge clk);
      chk("post_rsp_valid", rsp_valid, 0);
      chk("post_busy", busy, 0);
    end

    // Contention straight after reset: req0 wins first, then strict alternation.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_a = 4'd15; req0_b = 4'd15;
    req1_valid = 1'b1; req1_a = 4'd2;  req1_b = 4'd7;
    got_n = 0; last_t = 0;
    for (t = 0; t < 60 && got_n < 4; t++) begin
      @(negedge clk);
      if (rsp_valid) begin
        exp_id = req_id_t'(got_n % 2);
        exp_p  = (got_n % 2 == 0) ? 8'd225 : 8'd14;
        chk("cont_id", rsp_id, exp_id);
        chk("cont_product", rsp_product, exp_p);
        if (got_n > 0) chk("cont_spacing", t - last_t, 6);
        last_t = t;
        got_n++;
        if (got_n == 4) begin
          req0_valid = 1'b0; req1_valid = 1'b0;
        end
      end
    end
    chk("cont_count", got_n, 4);
    @(negedge clk);
    @(negedge clk);

    // Backpressure: response held, no second accept until the handshake.
    rsp_ready = 1'b0;
    accept(1'b0, 4'd3, 4'd5);
    req1_valid = 1'b1; req1_a = 4'd2; req1_b = 4'd7;
    wait_rsp(-1, 0, lat);
    chk("bp_latency", lat, 4);
    ok = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (!(rsp_valid && rsp_product == 8'd15 && rsp_id == 1'b0 &&
            !req0_ready && !req1_ready && busy)) ok = 1'b0;
      @(negedge clk);
    end
    chk("bp_stable", ok, 1);
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_released_valid", rsp_valid, 0);
    chk("bp_req1_ready", req1_ready, 1);
    @(posedge clk);
    @(negedge clk);
    req1_valid = 1'b0; req1_a = 4'd0; req1_b = 4'd0;
    wait_rsp(-1, 0, lat);
    chk("bp2_latency", lat, 4);
    chk("bp2_id", rsp_id, 1);
    chk("bp2_product", rsp_product, 14);
    @(negedge clk);

    // Mid-operation reset in the 2nd CALC cycle.
    accept(1'b0, 4'd9, 4'd9);
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 4'd6; req0_b = 4'd7;
    req1_valid = 1'b1; req1_a = 4'd5; req1_b = 4'd5;
    rst_n = 1'b0;
    #1;
    chk("mrst_rsp_valid", rsp_valid, 0);
    chk("mrst_product", rsp_product, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_readies", {req0_ready, req1_ready}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mrst_req0_first", {req0_ready, req1_ready}, 2'b10);
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_rsp(-1, 0, lat);
    chk("mrst_latency", lat, 4);
    chk("mrst_id", rsp_id, 0);
    chk("mrst_product2", rsp_product, 42);
    @(negedge clk);

    // Enable held low for 3 cycles during CALC.
    accept(1'b0, 4'd13, 4'd11);
    wait_rsp(1, 3, lat);
    chk("ena_latency", lat, 7);
    chk("ena_id", rsp_id, 0);
    chk("ena_product", rsp_product, 143);
    @(negedge clk);
    chk("ena_post_valid", rsp_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
